cpu_encode: RTL
===============

# cpu_encode

Streaming RV32I instruction encoder: the inverse of the core's field decoder. Accepts per-instruction fields (opcode, rd, rs1, rs2, func, immediate) over a valid/ready handshake, packs them into a 32-bit instruction word by format, and emits the word with a sequential word address for loading into instruction memory. It sits between the test-program generator and the instruction-memory write port. It rejects unencodable input and counts those rejections.

## Interface
- DEPTH_W, 10: word-address width; the program buffer holds 2^DEPTH_W words.
- BASE_ADDR, 0: word address of the first emitted instruction (DEPTH_W bits).
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_clear  in  1  synchronous clear of counters, error and state.
- i_valid  in  1  input fields valid.
- o_ready  out  1  encoder accepts fields this cycle.
- i_op  in  7  opcode.
- i_rd, i_rs1, i_rs2  in  5 each  register fields.
- i_func  in  10  {funct7, funct3}.
- i_imm  in  20  immediate, in the same field layout the decoder produces.
- o_inst_valid  out  1  o_inst/o_addr valid.
- i_inst_ready  in  1  downstream accepts the word.
- o_inst  out  32  encoded instruction.
- o_addr  out  DEPTH_W  word address of o_inst.
- o_full  out  1  buffer-full state.
- o_err  out  1  sticky: at least one input was rejected.
- o_err_count  out  8  number of rejected inputs, saturating at 255.
- o_word_count  out  DEPTH_W+1  number of words emitted since reset or clear.

## Operation
- Accept occurs on i_valid && o_ready.
- Format is selected by i_op:
  - U: 0110111, 0010111.
  - J: 1101111.
  - B: 1100011.
  - S: 0100011.
  - R: 0110011.
  - I: 1100111, 0000011, 0010011, 0001111, 1110011.
- Common packing: inst[6:0]=op.
- R: rd→[11:7], func[2:0]→[14:12], rs1→[19:15], rs2→[24:20], func[9:3]→[31:25].
- I: rd, funct3, rs1 as in R; imm[11:0]→[31:20].
- S: funct3, rs1, rs2 as in R; imm[11:5]→[31:25], imm[4:0]→[11:7].
- B: funct3, rs1, rs2 as in R; imm[11]→[31], imm[10]→[7], imm[9:4]→[30:25], imm[3:0]→[11:8].
- U: rd→[11:7]; imm[19:0]→[31:12].
- J: rd→[11:7]; imm[19]→[31], imm[9:0]→[30:21], imm[10]→[20], imm[18:11]→[19:12].
- Ignored fields: fields unused by a format are ignored and do not affect o_inst.
- Rejects:
  - Rejected input: an opcode outside the list, or an I/S/B input whose imm[19:12] is not all copies of imm[11].
  - A rejected input completes its handshake but produces no word.
  - It sets o_err and increments o_err_count, saturating at 255.
  - It does not advance the address.
- Addressing:
  - Accepted valid words get o_addr = BASE_ADDR + o_word_count, modulo 2^DEPTH_W.
  - o_word_count increments when the word is accepted.
- States:
  - RUN (reset state): o_ready = !o_inst_valid || i_inst_ready.
  - FULL: entered when a valid word is accepted and o_word_count reaches 2^DEPTH_W. In FULL, o_ready=0, o_full=1, and the pending output word still drains normally.
  - Clear exits FULL: i_clear returns the block to RUN.
- i_clear:
  - Zeroes o_word_count, o_err and o_err_count, and sets state to RUN.
  - Drops any pending output (o_inst_valid←0).
  - Has priority over a same-cycle accept; that input is not consumed (o_ready=0 while i_clear=1).

## Timing
- Reset (async assert, values held while i_rst_n=0):
  - o_inst_valid=0, o_inst=0, o_addr=0.
  - o_word_count=0, o_err=0, o_err_count=0, o_full=0.
  - State RUN.
- Latency and throughput:
  - Latency is 1 cycle: a word accepted at edge N has o_inst_valid=1 after edge N.
  - Throughput is one word per cycle while i_inst_ready=1.
- Output holding: o_inst and o_addr hold stable while o_inst_valid && !i_inst_ready.
- Drain/refill: on the same edge, the output register loads the next word when draining and accepting simultaneously, so no bubble is inserted.
- Reject vs. held output: a rejected input in the same cycle leaves the current output register untouched.
- o_ready is combinational from state, o_inst_valid, i_inst_ready and i_clear. It has no dependence on i_valid.
- Reset mid-operation discards any pending word. Counters restart from zero.

## Test plan
- Encodings by format (output = expected o_inst):
  - I: op=0010011, rd=1, func=0, rs1=0, imm=5 → 0x00500093.
  - R: op=0110011, rd=3, rs1=1, rs2=2, func=0 → 0x002081B3.
  - U: op=0110111, rd=5, imm=0x12345 → 0x123452B7.
  - S: op=0100011, func=2, rs1=1, rs2=2, imm=8 → 0x0020A423.
  - B: op=1100011, rs1=1, rs2=2, func=0, imm=4 → 0x00208463.
  - J: op=1101111, rd=1, imm=2 → 0x004000EF.
  - Addresses for this stream are 0..5.
- Rejects: op=0x7F; then I-type with imm=0x00800 → no word, o_err=1, o_err_count=2, o_word_count unchanged.
- Backpressure: hold i_inst_ready=0 for 3 cycles with a stream of inputs → o_ready=0, o_inst/o_addr stable; on release, words appear back-to-back with consecutive addresses.
- Full: DEPTH_W=2, BASE_ADDR=2, stream 5 words → addresses 2,3,0,1; o_full=1 after the 4th; 5th input stalls. i_clear → RUN, o_word_count=0, and the 5th word emits at address 2.
- Round-trip: 1000 random valid field sets through the encoder and then the core decoder → decoded op/rd/rs1/rs2/func/imm match inputs on the fields each format uses; decoder valid=1.
- Async reset asserted mid-stream with o_inst_valid=1 → all outputs zero immediately; first post-reset word at BASE_ADDR.

Source files
------------

// File: rtl/cpu_encode.sv
// Streaming RV32I instruction encoder: packs decoded instruction fields back
// into 32-bit words and tags each with a sequential instruction-memory address.
module cpu_encode #(
  parameter int unsigned DEPTH_W   = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [6:0]         i_op,
  input  logic [4:0]         i_rd,
  input  logic [4:0]         i_rs1,
  input  logic [4:0]         i_rs2,
  input  logic [9:0]         i_func,
  input  logic [19:0]        i_imm,
  output logic               o_inst_valid,
  input  logic               i_inst_ready,
  output logic [31:0]        o_inst,
  output logic [DEPTH_W-1:0] o_addr,
  output logic               o_full,
  output logic               o_err,
  output logic [7:0]         o_err_count,
  output logic [DEPTH_W:0]   o_word_count
);

  localparam int unsigned CNT_W = DEPTH_W + 1;
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(2**DEPTH_W - 1);
  localparam logic [DEPTH_W-1:0] BASE     = DEPTH_W'(BASE_ADDR);

  typedef enum logic {RUN = 1'b0, FULL = 1'b1} state_t;
  typedef enum logic [2:0] {F_R, F_I, F_S, F_B, F_U, F_J, F_BAD} fmt_t;

  state_t      state;
  fmt_t        fmt;
  logic [31:0] word;
  logic        encodable;
  logic        imm_ok;
  logic        accept;

  // Stalled in FULL, behind a held word, or while a clear is in progress.
  assign o_ready = (state == RUN) && (!o_inst_valid || i_inst_ready) && !i_clear;
  assign accept  = i_valid && o_ready;
  assign o_full  = (state == FULL);

  // Format selection and field packing.
  always_comb begin
    fmt       = F_BAD;
    word      = '0;
    encodable = 1'b0;
    imm_ok    = (i_imm[19:12] == {8{i_imm[11]}});
    case (i_op)
      7'b0110111, 7'b0010111: fmt = F_U;
      7'b1101111:             fmt = F_J;
      7'b1100011:             fmt = F_B;
      7'b0100011:             fmt = F_S;
      7'b0110011:             fmt = F_R;
      7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011: fmt = F_I;
      default:                fmt = F_BAD;
    endcase
    case (fmt)
      F_R: begin
        word      = {i_func[9:3], i_rs2, i_rs1, i_func[2:0], i_rd, i_op};
        encodable = 1'b1;
      end
      F_I: begin
        word      = {i_imm[11:0], i_rs1, i_func[2:0], i_rd, i_op};
        encodable = imm_ok;
      end
      F_S: begin
        word      = {i_imm[11:5], i_rs2, i_rs1, i_func[2:0], i_imm[4:0], i_op};
        encodable = imm_ok;
      end
      F_B: begin
        word      = {i_imm[11], i_imm[9:4], i_rs2, i_rs1, i_func[2:0],
                     i_imm[3:0], i_imm[10], i_op};
        encodable = imm_ok;
      end
      F_U: begin
        word      = {i_imm, i_rd, i_op};
        encodable = 1'b1;
      end
      F_J: begin
        word      = {i_imm[19], i_imm[9:0], i_imm[10], i_imm[18:11], i_rd, i_op};
        encodable = 1'b1;
      end
      default: begin
        word      = '0;
        encodable = 1'b0;
      end
    endcase
  end

  // Output register, counters and RUN/FULL state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= RUN;
      o_inst_valid <= 1'b0;
      o_inst       <= '0;
      o_addr       <= '0;
      o_err        <= 1'b0;
      o_err_count  <= '0;
      o_word_count <= '0;
    end else if (i_clear) begin
      state        <= RUN;
      o_inst_valid <= 1'b0;
      o_err        <= 1'b0;
      o_err_count  <= '0;
      o_word_count <= '0;
    end else begin
      if (o_inst_valid && i_inst_ready) begin
        o_inst_valid <= 1'b0;
      end
      if (accept && encodable) begin
        o_inst_valid <= 1'b1;
        o_inst       <= word;
        o_addr       <= BASE + o_word_count[DEPTH_W-1:0];
        o_word_count <= o_word_count + CNT_W'(1);
        if (o_word_count == LAST_CNT) begin
          state <= FULL;
        end
      end else if (accept) begin
        o_err <= 1'b1;
        if (o_err_count != 8'hFF) begin
          o_err_count <= o_err_count + 8'd1;
        end
      end
    end
  end

endmodule
